// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: funct3 encodings and the sequential PC step.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    localparam int PC_INC = 4;

endpackage

// File: rtl/branch_resolve_if.sv
// Request/result handshake bundle between the issue stage and the branch resolver.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;

    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_mispredict;
    logic            out_illegal;
    logic [XLEN-1:0] out_target;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_taken, out_mispredict, out_illegal, out_target
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
        output in_ready, out_valid, out_taken, out_mispredict, out_illegal, out_target
    );
endinterface

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation; unknown funct3 is flagged illegal and never taken.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);
    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLT:  taken = lt_s;
            BR_BGE:  taken = !lt_s;
            BR_BLTU: taken = lt_u;
            BR_BGEU: taken = !lt_u;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_resolve.sv
// Branch resolver with a one-entry registered result stage and valid/ready handshakes.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    branch_resolve_if.slave       bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_branches,
    output logic [CNT_W-1:0]      stat_mispredicts
`endif
);
    generate
        if (!(XLEN == 32 || XLEN == 64) || CNT_W < 1) begin : g_param_check
            $error("branch_resolve: XLEN must be 32 or 64 and CNT_W at least 1");
        end
    endgenerate

    logic            cmp_taken;
    logic            cmp_illegal;
    logic            accept;

    logic            valid_q,      valid_d;
    logic            taken_q,      taken_d;
    logic            mispredict_q, mispredict_d;
    logic            illegal_q,    illegal_d;
    logic [XLEN-1:0] target_q,     target_d;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (bus.in_funct3),
        .rs1     (bus.in_rs1),
        .rs2     (bus.in_rs2),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign bus.in_ready = !flush && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d      = valid_q;
        taken_d      = taken_q;
        mispredict_d = mispredict_q;
        illegal_d    = illegal_q;
        target_d     = target_q;
        // Flush wins over both the consumer handshake and any new accept.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d      = 1'b1;
            taken_d      = cmp_taken;
            illegal_d    = cmp_illegal;
            mispredict_d = !cmp_illegal && (cmp_taken != bus.in_pred_taken);
            target_d     = cmp_taken ? (bus.in_pc + bus.in_imm)
                                     : (bus.in_pc + XLEN'(PC_INC));
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            target_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            target_q     <= target_d;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_taken      = taken_q;
    assign bus.out_mispredict = mispredict_q;
    assign bus.out_illegal    = illegal_q;
    assign bus.out_target     = target_q;

`ifdef BRANCH_STATS_EN
    logic             count_en;
    logic [CNT_W-1:0] branches_q,    branches_d;
    logic [CNT_W-1:0] mispredicts_q, mispredicts_d;

    // Only consumed legal results count; a result dropped by flush is never seen.
    assign count_en = valid_q && bus.out_ready && !flush && !illegal_q;

    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (count_en) begin
            branches_d = branches_q + 1'b1;
            if (mispredict_q) begin
                mispredicts_d = mispredicts_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Directed, table-driven bench for branch_resolve plus handshake, flush and reset sequences.
module tb_branch_resolve;
    import branch_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    logic flush;

    branch_resolve_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;
`endif

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .bus              (bus.slave)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [14];
    vec_t v;

    int n_checks = 0;
    int n_errors = 0;
    int exp_br   = 0;
    int exp_mis  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t r);
        bus.in_funct3     = r.f3;
        bus.in_rs1        = r.rs1;
        bus.in_rs2        = r.rs2;
        bus.in_pc         = r.pc;
        bus.in_imm        = r.imm;
        bus.in_pred_taken = r.pred;
        bus.in_valid      = 1'b1;
    endtask

    task automatic check_out(input string tag, input vec_t r);
        chk({tag, ".out_valid"},      {63'd0, bus.out_valid},      64'd1);
        chk({tag, ".out_taken"},      {63'd0, bus.out_taken},      {63'd0, r.taken});
        chk({tag, ".out_mispredict"}, {63'd0, bus.out_mispredict}, {63'd0, r.mis});
        chk({tag, ".out_illegal"},    {63'd0, bus.out_illegal},    {63'd0, r.ill});
        chk({tag, ".out_target"},     {32'd0, bus.out_target},     {32'd0, r.tgt});
        $display("txn %s f3=%b rs1=%h rs2=%h pc=%h -> taken=%0d mis=%0d ill=%0d tgt=%h",
                 tag, r.f3, r.rs1, r.rs2, r.pc, bus.out_taken, bus.out_mispredict,
                 bus.out_illegal, bus.out_target);
    endtask

    // Model counts a result when it is consumed.
    task automatic count(input vec_t r);
        if (!r.ill) begin
            exp_br++;
            if (r.mis) exp_mis++;
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
        chk({tag, ".stat_branches"},    {60'd0, stat_branches},    64'(exp_br  % (1 << CNT_W)));
        chk({tag, ".stat_mispredicts"}, {60'd0, stat_mispredicts}, 64'(exp_mis % (1 << CNT_W)));
`else
        $display("stats %s not built", tag);
`endif
    endtask

    // One request with out_ready high; the result is consumed on the following edge.
    task automatic apply_vec(input string tag, input vec_t r);
        @(posedge clk); #1;
        drive_req(r);
        bus.out_ready = 1'b1;
        #1 chk({tag, ".in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_out(tag, r);
        count(r);
    endtask

    initial begin
        vecs[0]  = '{3'b100, 32'hFFFF_FFFF, 32'h1,         32'h100,       32'h20,        1'b1, 1'b1, 1'b0, 1'b0, 32'h120};
        vecs[1]  = '{3'b110, 32'hFFFF_FFFF, 32'h1,         32'h100,       32'h20,        1'b1, 1'b0, 1'b1, 1'b0, 32'h104};
        vecs[2]  = '{3'b000, 32'h5,         32'h5,         32'h200,       32'h8,         1'b0, 1'b1, 1'b1, 1'b0, 32'h208};
        vecs[3]  = '{3'b010, 32'h5,         32'h5,         32'h300,       32'h40,        1'b1, 1'b0, 1'b0, 1'b1, 32'h304};
        vecs[4]  = '{3'b011, 32'h5,         32'h6,         32'h400,       32'h40,        1'b0, 1'b0, 1'b0, 1'b1, 32'h404};
        vecs[5]  = '{3'b001, 32'h5,         32'h5,         32'h500,       32'h40,        1'b0, 1'b0, 1'b0, 1'b0, 32'h504};
        vecs[6]  = '{3'b101, 32'h1,         32'hFFFF_FFFF, 32'h600,       32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5F0};
        vecs[7]  = '{3'b111, 32'h1,         32'hFFFF_FFFF, 32'h700,       32'h40,        1'b0, 1'b0, 1'b0, 1'b0, 32'h704};
        vecs[8]  = '{3'b000, 32'h9,         32'h9,         32'hFFFF_FFF8, 32'h10,        1'b1, 1'b1, 1'b0, 1'b0, 32'h8};
        vecs[9]  = '{3'b001, 32'h9,         32'h9,         32'hFFFF_FFFC, 32'h10,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{3'b100, 32'h7,         32'h7,         32'h800,       32'h40,        1'b0, 1'b0, 1'b0, 1'b0, 32'h804};
        vecs[11] = '{3'b101, 32'h7,         32'h7,         32'h900,       32'h100,       1'b0, 1'b1, 1'b1, 1'b0, 32'hA00};
        vecs[12] = '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         32'hC,         1'b1, 1'b1, 1'b0, 1'b0, 32'hC};
        vecs[13] = '{3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         32'hC,         1'b0, 1'b0, 1'b0, 1'b0, 32'h4};

        rst_n             = 1'b0;
        flush             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_funct3     = 3'b000;
        bus.in_rs1        = '0;
        bus.in_rs2        = '0;
        bus.in_pc         = '0;
        bus.in_imm        = '0;
        bus.in_pred_taken = 1'b0;
        bus.out_ready     = 1'b0;

        #2;
        chk("rst.out_valid",      {63'd0, bus.out_valid},      64'd0);
        chk("rst.out_taken",      {63'd0, bus.out_taken},      64'd0);
        chk("rst.out_mispredict", {63'd0, bus.out_mispredict}, 64'd0);
        chk("rst.out_illegal",    {63'd0, bus.out_illegal},    64'd0);
        chk("rst.out_target",     {32'd0, bus.out_target},     64'd0);
        check_stats("rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 14; k++) begin
            apply_vec($sformatf("vec%0d", k), vecs[k]);
        end
        @(posedge clk); #1;
        chk("drain.out_valid", {63'd0, bus.out_valid}, 64'd0);

        // Back-to-back with consumer stalled for two cycles after the first result.
        begin
            vec_t a, b, c;
            a = '{3'b000, 32'h3, 32'h3, 32'h1000, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1040};
            b = '{3'b001, 32'h3, 32'h3, 32'h2000, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2004};
            c = '{3'b110, 32'h1, 32'h2, 32'h3000, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3080};
            @(posedge clk); #1;
            drive_req(a);
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            drive_req(b);
            #1 chk("b2b.stall1.in_ready", {63'd0, bus.in_ready}, 64'd0);
            check_out("b2b.A.stall1", a);
            @(posedge clk); #2;
            chk("b2b.stall2.in_ready", {63'd0, bus.in_ready}, 64'd0);
            check_out("b2b.A.stall2", a);
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            #1 chk("b2b.release.in_ready", {63'd0, bus.in_ready}, 64'd1);
            check_out("b2b.A.release", a);
            @(posedge clk); #1;
            count(a);
            check_out("b2b.B", b);
            drive_req(c);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            count(b);
            check_out("b2b.C", c);
            @(posedge clk); #1;
            count(c);
            chk("b2b.drain.out_valid", {63'd0, bus.out_valid}, 64'd0);
        end

        // Flush while a legal result is held and a new request is offered.
        begin
            vec_t d, e;
            d = '{3'b100, 32'h1, 32'h2, 32'h4000, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4008};
            e = '{3'b000, 32'h1, 32'h1, 32'h4100, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4108};
            @(posedge clk); #1;
            drive_req(d);
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            check_out("flush.D", d);
            drive_req(e);
            flush         = 1'b1;
            bus.out_ready = 1'b1;
            #1 chk("flush.in_ready", {63'd0, bus.in_ready}, 64'd0);
            @(posedge clk); #1;
            flush        = 1'b0;
            bus.in_valid = 1'b0;
            chk("flush.out_valid", {63'd0, bus.out_valid}, 64'd0);
            check_stats("flush");
            @(posedge clk); #1;
            chk("flush.no_accept.out_valid", {63'd0, bus.out_valid}, 64'd0);
        end

        // Two more legal, correctly predicted branches bring the total to 17.
        v = '{3'b111, 32'h5, 32'h5, 32'h5000, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5010};
        apply_vec("extra0", v);
        v = '{3'b001, 32'h1, 32'h2, 32'h6000, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h6020};
        apply_vec("extra1", v);
        @(posedge clk); #1;
        chk("total.branches_model", 64'(exp_br), 64'd17);
        chk("total.mispredicts_model", 64'(exp_mis), 64'd5);
        check_stats("total");

        // Asynchronous reset while a result is held.
        begin
            vec_t f, g;
            f = '{3'b000, 32'h9, 32'h9, 32'h7000, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7004};
            g = '{3'b101, 32'hFFFF_FFFF, 32'h0, 32'h8000, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8004};
            drive_req(f);
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check_out("rstmid.F", f);
            #2 rst_n = 1'b0;
            #1;
            exp_br  = 0;
            exp_mis = 0;
            chk("rstmid.out_valid",  {63'd0, bus.out_valid},  64'd0);
            chk("rstmid.out_taken",  {63'd0, bus.out_taken},  64'd0);
            chk("rstmid.out_target", {32'd0, bus.out_target}, 64'd0);
            check_stats("rstmid");
            @(posedge clk); #1;
            rst_n = 1'b1;
            drive_req(g);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check_out("rstmid.G", g);
            count(g);
            @(posedge clk); #1;
            chk("rstmid.drain.out_valid", {63'd0, bus.out_valid}, 64'd0);
            check_stats("after_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
- REQ-001 SHALL have parameter XLEN, default 32, operand/PC/target width (legal: 32, 64).
- REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
- REQ-003 SHALL have port clk  input  1  single clock, rising edge.
- REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005 SHALL have port flush  input  1  discard held and incoming result.
- REQ-006 SHALL have port in_valid  input  1  request valid.
- REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
- REQ-008 SHALL have port in_funct3  input  3  branch op: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- REQ-009 SHALL have ports in_rs1, in_rs2  input  XLEN  compare operands.
- REQ-010 SHALL have ports in_pc, in_imm  input  XLEN  branch PC, sign-extended offset.
- REQ-011 SHALL have port in_pred_taken  input  1  fetch-stage prediction.
- REQ-012 SHALL have port out_valid  output  1  result valid.
- REQ-013 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
- REQ-014 SHALL have ports out_taken, out_mispredict, out_illegal  output  1  each, resolved outcome.
- REQ-015 SHALL have port out_target  output  XLEN  next PC.
- REQ-016 SHALL have ports stat_branches, stat_mispredicts  output  CNT_W  each, present only with BRANCH_STATS_EN.

Function
- REQ-017 SHALL register one result; latency from accept to out_valid exactly 1 cycle.
- REQ-018 SHALL drive in_ready = !flush && (!out_valid || out_ready), combinational; back-to-back throughput 1/cycle.
- REQ-019 SHALL hold all out_* stable while out_valid && !out_ready.
- REQ-020 SHALL compare BLT/BGE as two's-complement signed, BLTU/BGEU as unsigned, BEQ/BNE bitwise.
- REQ-021 SHALL set out_target = in_pc + in_imm if taken, else in_pc + 4, both modulo 2^XLEN (wrap, no carry out).
- REQ-022 SHALL treat funct3 010/011 as illegal: out_illegal=1, out_taken=0, out_mispredict=0, out_target = in_pc + 4.
- REQ-023 SHALL set out_mispredict = (out_taken != in_pred_taken) for legal ops.
- REQ-024 SHALL on flush clear out_valid next edge, drop any held result, and accept no request that cycle; flush has priority over all handshakes.
- REQ-025 SHALL load a new result when a request is accepted; out_valid clears when result consumed and no new accept.

Reset
- REQ-026 SHALL, on rst_n low, immediately force out_valid, out_taken, out_mispredict, out_illegal to 0, out_target to 0, counters to 0.
- REQ-027 SHALL discard any held result on reset mid-operation; first accept possible on the first edge after rst_n deasserts.

Configuration
- REQ-028 SHALL compile statistics only when macro BRANCH_STATS_EN is defined.
- REQ-029 With BRANCH_STATS_EN: stat_branches increments per output handshake of a legal op; stat_mispredicts increments on those with out_mispredict=1; both wrap at 2^CNT_W; flushed results never counted.
- REQ-030 Without BRANCH_STATS_EN: stat ports and counters SHALL not exist; all other behaviour identical.

Structure
- REQ-031 SHALL take funct3 encodings (BR_BEQ ... BR_BGEU) and the PC increment constant 4 from shared package branch_pkg.
- REQ-032 SHALL place combinational compare in one sub-module branch_cmp (inputs funct3, rs1, rs2; outputs taken, illegal); registers and handshake in branch_resolve.

Verification
- REQ-033 BLT rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x20 -> taken=1, target=0x120; same operands BLTU -> taken=0, target=0x104.
- REQ-034 BEQ equal operands, pred_taken=0 -> taken=1, mispredict=1; funct3=010 -> illegal=1, taken=0, target=pc+4.
- REQ-035 Three back-to-back requests, out_ready held 0 for 2 cycles after first -> in_ready low, first result stable, none lost, in order.
- REQ-036 flush asserted with out_valid=1 and in_valid=1 -> in_ready=0, out_valid=0 next cycle, stats unchanged.
- REQ-037 pc=0xFFFF_FFF8, imm=0x10, taken -> target=0x0000_0008; not taken pc=0xFFFF_FFFC -> target=0.
- REQ-038 BRANCH_STATS_EN, CNT_W=4: 17 legal handshakes, 5 mispredicted -> stat_branches=1, stat_mispredicts=5; rst_n pulse mid-stream -> both 0, out_valid=0 asynchronously.
